accelerator_write_heads: RTL

NTM write-head datapath, the write-side counterpart of the read heads. Applies the erase/add memory update M'[j][k] = M[j][k]·(1 − w[j]·e[k]) + w[j]·a[k] over an N×W memory. Erase and add vectors are loaded once per operation. Memory rows and per-row weights are then streamed in from the controller, and updated words are streamed out for write-back.

---
 rtl/accelerator_write_heads.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/accelerator_write_heads.sv
// NTM write head: streams memory words through the erase/add update
// M' = M - M*(w*e[k]) + w*a[k] using the loaded e/a vectors and a per-row weight.
module accelerator_write_heads #(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32,
    parameter int CONTROL_SIZE  = 4,
    parameter int N             = 64,
    parameter int W             = 64,
    localparam int JW = (N > 1) ? $clog2(N) : 1,
    localparam int KW = (W > 1) ? $clog2(W) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 VECTOR_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] E_IN,
    input  logic [DATA_SIZE-1:0] A_IN,
    input  logic                 W_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] W_IN,
    input  logic                 M_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] M_IN,
    output logic                 M_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] M_OUT,
    output logic [JW-1:0]        INDEX_J_OUT,
    output logic [KW-1:0]        INDEX_K_OUT,
    output logic                 BUSY,
    output logic                 READY
);

    typedef enum logic [2:0] {
        IDLE, LOAD_VECTORS, LOAD_WEIGHT, STREAM, DONE
    } state_t;

    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    if (CONTROL_SIZE < 1) begin : g_ctrl_field_empty
    end

    // Fixed-point multiply: full-width product, arithmetic shift, wrap to DATA_SIZE.
    function automatic logic signed [DATA_SIZE-1:0] fx_mul(
        input logic signed [DATA_SIZE-1:0] x,
        input logic signed [DATA_SIZE-1:0] y
    );
        logic signed [2*DATA_SIZE-1:0] p;
        logic signed [2*DATA_SIZE-1:0] p_sh;
        p    = {{DATA_SIZE{x[DATA_SIZE-1]}}, x} * {{DATA_SIZE{y[DATA_SIZE-1]}}, y};
        p_sh = p >>> FRACTION_SIZE;
        return p_sh[DATA_SIZE-1:0];
    endfunction

    state_t                      r_state;
    logic        [JW-1:0]        r_j;
    logic        [KW-1:0]        r_k;
    logic signed [DATA_SIZE-1:0] r_w;
    logic        [DATA_SIZE-1:0] r_e [W];
    logic        [DATA_SIZE-1:0] r_a [W];
    logic                        r_mout_en;
    logic        [DATA_SIZE-1:0] r_mout;
    logic        [JW-1:0]        r_oj;
    logic        [KW-1:0]        r_ok;
    logic                        r_busy;
    logic                        r_ready;

    logic                        w_vec_wr;
    logic signed [DATA_SIZE-1:0] w_we;
    logic signed [DATA_SIZE-1:0] w_wa;
    logic signed [DATA_SIZE-1:0] w_upd;

    assign w_vec_wr = (r_state == LOAD_VECTORS) && VECTOR_IN_ENABLE;
    assign w_we     = fx_mul(r_w, r_e[r_k]);
    assign w_wa     = fx_mul(r_w, r_a[r_k]);
    assign w_upd    = $signed(M_IN) - fx_mul($signed(M_IN), w_we) + w_wa;

    // Vector storage carries no reset; its contents are always rewritten before use.
    always_ff @(posedge CLK) begin
        if (w_vec_wr) begin
            r_e[r_k] <= E_IN;
            r_a[r_k] <= A_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_j       <= '0;
            r_k       <= '0;
            r_w       <= '0;
            r_mout_en <= 1'b0;
            r_mout    <= '0;
            r_oj      <= '0;
            r_ok      <= '0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_mout_en <= 1'b0;
            r_ready   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_state <= LOAD_VECTORS;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD_VECTORS: begin
                    if (VECTOR_IN_ENABLE) begin
                        if (r_k == K_LAST) begin
                            r_k     <= '0;
                            r_state <= LOAD_WEIGHT;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                LOAD_WEIGHT: begin
                    if (W_IN_ENABLE) begin
                        r_w     <= $signed(W_IN);
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (M_IN_ENABLE) begin
                        r_mout_en <= 1'b1;
                        r_mout    <= w_upd;
                        r_oj      <= r_j;
                        r_ok      <= r_k;
                        if (r_k == K_LAST) begin
                            r_k <= '0;
                            if (r_j == J_LAST) begin
                                r_state <= DONE;
                            end else begin
                                r_j     <= r_j + 1'b1;
                                r_state <= LOAD_WEIGHT;
                            end
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign M_OUT_ENABLE = r_mout_en;
    assign M_OUT        = r_mout;
    assign INDEX_J_OUT  = r_oj;
    assign INDEX_K_OUT  = r_ok;
    assign BUSY         = r_busy;
    assign READY        = r_ready;

endmodule
